stream_min_tracker: RTL

// - Streaming minimum finder: the min-side counterpart to the team's max comparator.
// - Accepts a frame of FRAME_LEN unsigned values over a valid/ready input.
// - Reports the frame minimum and the index where it first occurs over a valid/ready output.
// - Sits between a sample source (switches/ADC sequencer) and the display/result logic.
//

---
 rtl/stream_min_tracker.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/stream_min_tracker.sv
// Streaming frame minimum finder: reports the smallest of FRAME_LEN samples and its first index.
// Define STREAM_MIN_TRACK_MAX_EN to also track the frame maximum and its first index.
module stream_min_tracker #(
    parameter int WIDTH     = 4,
    parameter int FRAME_LEN = 8,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [IDX_W-1:0] out_idx,
    output logic             busy,
`ifdef STREAM_MIN_TRACK_MAX_EN
    output logic [WIDTH-1:0] out_max,
    output logic [IDX_W-1:0] out_max_idx,
`endif
    output logic [1:0]       dbg_state
);

    // Handshake rule on both sides: a transfer happens at a rising edge where valid and ready are both 1.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(FRAME_LEN - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_ready_en;
    logic [IDX_W:0]   r_count;
    logic [WIDTH-1:0] r_acc_min;
    logic [IDX_W-1:0] r_acc_idx;
    logic [WIDTH-1:0] r_out_min;
    logic [IDX_W-1:0] r_out_idx;

    logic             w_beat;
    logic             w_last;
    logic             w_lt;
    logic [IDX_W-1:0] w_cnt_idx;

    assign w_beat    = in_valid & in_ready;
    assign w_last    = w_beat && (r_state == S_ACCUM) && (r_count == LAST_CNT);
    assign w_lt      = in_data < r_acc_min;
    assign w_cnt_idx = r_count[IDX_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_beat)    w_next_state = S_ACCUM;
            S_ACCUM: if (w_last)    w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    // in_ready stays low while reset is held and for the edge-free gap right after release.
    always_comb begin
        in_ready  = r_ready_en && (r_state != S_DONE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
        dbg_state = r_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready_en <= 1'b0;
            r_count    <= '0;
            r_acc_min  <= '0;
            r_acc_idx  <= '0;
            r_out_min  <= '0;
            r_out_idx  <= '0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_beat && (r_state == S_IDLE)) begin
                r_acc_min <= in_data;
                r_acc_idx <= '0;
                r_count   <= (IDX_W+1)'(1);
            end else if (w_beat && (r_state == S_ACCUM)) begin
                r_count <= r_count + 1'b1;
                if (w_lt) begin
                    r_acc_min <= in_data;
                    r_acc_idx <= w_cnt_idx;
                end
                // Output registers load on the final beat so they hold across the next frame.
                if (w_last) begin
                    r_out_min <= w_lt ? in_data : r_acc_min;
                    r_out_idx <= w_lt ? w_cnt_idx : r_acc_idx;
                end
            end else if ((r_state == S_DONE) && out_ready) begin
                r_count <= '0;
            end
        end
    end

    assign out_min = r_out_min;
    assign out_idx = r_out_idx;

`ifdef STREAM_MIN_TRACK_MAX_EN
    logic [WIDTH-1:0] r_acc_max;
    logic [IDX_W-1:0] r_acc_max_idx;
    logic [WIDTH-1:0] r_out_max;
    logic [IDX_W-1:0] r_out_max_idx;
    logic             w_gt;

    assign w_gt = in_data > r_acc_max;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc_max     <= '0;
            r_acc_max_idx <= '0;
            r_out_max     <= '0;
            r_out_max_idx <= '0;
        end else if (w_beat && (r_state == S_IDLE)) begin
            r_acc_max     <= in_data;
            r_acc_max_idx <= '0;
        end else if (w_beat && (r_state == S_ACCUM)) begin
            if (w_gt) begin
                r_acc_max     <= in_data;
                r_acc_max_idx <= w_cnt_idx;
            end
            if (w_last) begin
                r_out_max     <= w_gt ? in_data : r_acc_max;
                r_out_max_idx <= w_gt ? w_cnt_idx : r_acc_max_idx;
            end
        end
    end

    assign out_max     = r_out_max;
    assign out_max_idx = r_out_max_idx;
`endif

endmodule
